// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types and constants
package uart_pkg;

    typedef enum logic [2:0] {
        TX_IDLE   = 3'd0,
        TX_FETCH  = 3'd1,
        TX_LOAD   = 3'd2,
        TX_START  = 3'd3,
        TX_DATA   = 3'd4,
        TX_PARITY = 3'd5,
        TX_STOP   = 3'd6
    } tx_state_e;

    localparam int UART_DATA_BITS = 8;
    localparam int UART_MIN_DIV   = 2;

endpackage

// File: rtl/uart_baud_gen.sv
// rtl/uart_baud_gen.sv - loadable bit-period down-counter shared by TX and RX
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int DIV_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [DIV_W-1:0] div_i,
    output logic             bit_tick_o
);

    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] div_eff;

    // Divisors below the minimum would give a zero-length or one-cycle bit.
    assign div_eff = (div_i < DIV_W'(UART_MIN_DIV)) ? DIV_W'(UART_MIN_DIV) : div_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            div_q <= '0;
            cnt_q <= '0;
        end else if (load_i) begin
            div_q <= div_eff;
            cnt_q <= div_eff;
        end else if (cnt_q == DIV_W'(1)) begin
            cnt_q <= div_q;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - DIV_W'(1);
        end
    end

    assign bit_tick_o = (cnt_q == DIV_W'(1));

endmodule

// File: rtl/uart_tx_core.sv
// rtl/uart_tx_core.sv - UART transmit engine draining a TX FIFO onto the serial pin
module uart_tx_core
    import uart_pkg::*;
#(
    parameter int DIV_W     = 16,
    parameter bit PARITY_EN = 1'b0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             tx_en_i,
    input  logic [DIV_W-1:0] baud_div_i,
    input  logic             parity_odd_i,
    input  logic             stop2_i,
    input  logic             fifo_empty_i,
    output logic             fifo_rd_en_o,
    input  logic [7:0]       fifo_data_i,
    output logic             tx_o,
    output logic             busy_o,
    output logic             tx_done_o
);

    tx_state_e  state_q, state_d;
    logic [7:0] shift_q, shift_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic       stop2_q, stop2_d;
    logic       par_q, par_d;
    logic       stop_cnt_q, stop_cnt_d;
    logic       bit_tick;
    logic       load;

    assign load = (state_q == TX_LOAD);

    uart_baud_gen #(.DIV_W(DIV_W)) u_baud (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .load_i     (load),
        .div_i      (baud_div_i),
        .bit_tick_o (bit_tick)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= TX_IDLE;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            stop2_q    <= 1'b0;
            par_q      <= 1'b0;
            stop_cnt_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            stop2_q    <= stop2_d;
            par_q      <= par_d;
            stop_cnt_q <= stop_cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        bit_cnt_d    = bit_cnt_q;
        stop2_d      = stop2_q;
        par_d        = par_q;
        stop_cnt_d   = stop_cnt_q;
        fifo_rd_en_o = 1'b0;
        tx_done_o    = 1'b0;
        tx_o         = 1'b1;
        busy_o       = (state_q != TX_IDLE);

        unique case (state_q)
            TX_IDLE: begin
                if (tx_en_i && !fifo_empty_i) state_d = TX_FETCH;
            end
            TX_FETCH: begin
                fifo_rd_en_o = 1'b1;
                state_d      = TX_LOAD;
            end
            TX_LOAD: begin
                // Parity is fixed from the whole byte here, so it survives the shifting.
                shift_d    = fifo_data_i;
                stop2_d    = stop2_i;
                par_d      = (^fifo_data_i) ^ parity_odd_i;
                bit_cnt_d  = '0;
                stop_cnt_d = 1'b0;
                state_d    = TX_START;
            end
            TX_START: begin
                tx_o = 1'b0;
                if (bit_tick) state_d = TX_DATA;
            end
            TX_DATA: begin
                tx_o = shift_q[0];
                if (bit_tick) begin
                    shift_d   = shift_q >> 1;
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'(UART_DATA_BITS - 1)) begin
                        state_d = PARITY_EN ? TX_PARITY : TX_STOP;
                    end
                end
            end
            TX_PARITY: begin
                tx_o = par_q;
                if (bit_tick) state_d = TX_STOP;
            end
            TX_STOP: begin
                if (bit_tick) begin
                    if (stop2_q && !stop_cnt_q) begin
                        stop_cnt_d = 1'b1;
                    end else begin
                        stop_cnt_d = 1'b0;
                        tx_done_o  = 1'b1;
                        state_d    = TX_IDLE;
                    end
                end
            end
            default: state_d = TX_IDLE;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_core.sv
// tb/tb_uart_tx_core.sv - self-checking bench for uart_tx_core
module tb_uart_tx_core;

    localparam int DIV_W = 16;

    typedef struct packed {
        logic tx;
        logic busy;
        logic rd;
        logic done;
        logic load;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             tx_en;
    logic [DIV_W-1:0] baud_div;
    logic             parity_odd;
    logic             stop2;

    logic [7:0] fmem  [2][16];
    int         ftail [2] = '{0, 0};
    logic       tx_w   [2];
    logic       busy_w [2];
    logic       done_w [2];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    function automatic void check(input string name, input int act, input int req);
        n_tests++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: actual %0d required %0d", name, act, req);
        end
    endfunction

    // Instance 0 has no parity, instance 1 appends parity.
    for (genvar g = 0; g < 2; g++) begin : m
        logic       rd, tx, busy, done, fempty;
        logic [7:0] fdata;
        int         fhead    = 0;
        int         rd_cnt   = 0;
        int         done_cnt = 0;
        exp_t       eq[$];
        logic [7:0] cur_byte;

        assign fempty    = (fhead == ftail[g]);
        assign tx_w[g]   = tx;
        assign busy_w[g] = busy;
        assign done_w[g] = done;

        uart_tx_core #(.DIV_W(DIV_W), .PARITY_EN(g == 1)) dut (
            .clk_i        (clk),
            .rst_ni       (rst_n),
            .tx_en_i      (tx_en),
            .baud_div_i   (baud_div),
            .parity_odd_i (parity_odd),
            .stop2_i      (stop2),
            .fifo_empty_i (fempty),
            .fifo_rd_en_o (rd),
            .fifo_data_i  (fdata),
            .tx_o         (tx),
            .busy_o       (busy),
            .tx_done_o    (done)
        );

        always @(posedge clk) begin
            if (rd) begin
                fdata <= fmem[g][fhead % 16];
                fhead <= fhead + 1;
            end
        end

        always @(negedge clk) begin
            if (rd)   rd_cnt   <= rd_cnt + 1;
            if (done) done_cnt <= done_cnt + 1;
        end

        // Expected line activity: a frame is a list of bits, each held for one bit period.
        always @(negedge clk) begin
            exp_t        e;
            int          p;
            int          nb;
            logic [11:0] bits;
            e = '{tx: 1'b1, busy: 1'b0, rd: 1'b0, done: 1'b0, load: 1'b0};
            if (!rst_n) begin
                eq.delete();
            end else if (eq.size() > 0) begin
                e = eq.pop_front();
            end else if (tx_en && !fempty) begin
                cur_byte = fmem[g][fhead % 16];
                eq.push_back('{tx: 1'b1, busy: 1'b1, rd: 1'b1, done: 1'b0, load: 1'b0});
                eq.push_back('{tx: 1'b1, busy: 1'b1, rd: 1'b0, done: 1'b0, load: 1'b1});
            end
            check($sformatf("inst%0d tx/busy/rd/done", g),
                  int'({tx, busy, rd, done}), int'({e.tx, e.busy, e.rd, e.done}));
            if (e.load && rst_n) begin
                p        = (baud_div < 2) ? 2 : int'(baud_div);
                bits     = '0;
                bits[8:1] = cur_byte;
                nb       = 9;
                if (g == 1) begin
                    bits[9] = (^cur_byte) ^ parity_odd;
                    nb      = 10;
                end
                bits[nb] = 1'b1;
                nb++;
                if (stop2) begin
                    bits[nb] = 1'b1;
                    nb++;
                end
                for (int i = 0; i < nb; i++) begin
                    for (int j = 0; j < p; j++) begin
                        eq.push_back('{tx: bits[i], busy: 1'b1, rd: 1'b0,
                                       done: (i == nb - 1) && (j == p - 1), load: 1'b0});
                    end
                end
            end
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic push(input int k, input logic [7:0] b);
        fmem[k][ftail[k] % 16] = b;
        ftail[k] = ftail[k] + 1;
    endtask

    task automatic wait_fall(input int k);
        int t = 0;
        while (tx_w[k] !== 1'b0 && t < 400) begin
            @(negedge clk);
            t++;
        end
        if (t >= 400) begin
            n_tests++;
            n_fail++;
            $display("FAIL start_bit_timeout: inst%0d tx stayed 1, required 0", k);
        end
    endtask

    task automatic count_done(input int k, input int start, output int c);
        c = start;
        while (done_w[k] !== 1'b1 && c < 400) begin
            @(negedge clk);
            c++;
        end
        if (c >= 400) begin
            n_tests++;
            n_fail++;
            $display("FAIL done_timeout: inst%0d no tx_done within 400 clks, required a pulse", k);
        end
    endtask

    // Samples the first clock of each bit; done_off counts clocks with the first start clock as 1.
    task automatic capture(input int k, input int p, input int n,
                           output logic [15:0] bits, output int done_off);
        int c = 1;
        bits = '0;
        wait_fall(k);
        while (done_w[k] !== 1'b1 && c < 400) begin
            if ((c - 1) % p == 0 && (c - 1) / p < n) bits[(c - 1) / p] = tx_w[k];
            @(negedge clk);
            c++;
        end
        if ((c - 1) % p == 0 && (c - 1) / p < n) bits[(c - 1) / p] = tx_w[k];
        done_off = c;
    endtask

    initial begin
        logic [15:0] bits;
        int          doff;
        int          r0;
        int          d0;
        int          gap;

        rst_n      = 1'b0;
        tx_en      = 1'b0;
        baud_div   = 16'd4;
        parity_odd = 1'b0;
        stop2      = 1'b0;
        step(3);
        check("reset tx_o", int'(tx_w[0]), 1);
        check("reset busy_o", int'(busy_w[0]), 0);
        check("reset tx_done_o", int'(done_w[1]), 0);
        rst_n = 1'b1;
        step(2);

        // 0xA5 at div 4, no parity
        tx_en = 1'b1;
        r0 = m[0].rd_cnt;
        push(0, 8'hA5);
        capture(0, 4, 10, bits, doff);
        check("a5 bits", int'(bits), 16'h034A);
        check("a5 done clk", doff, 40);
        step();
        check("a5 rd pulses", m[0].rd_cnt - r0, 1);

        // 0xA5 at div 3 with even then odd parity and two stop bits
        baud_div = 16'd3;
        push(1, 8'hA5);
        capture(1, 3, 11, bits, doff);
        check("even parity bits", int'(bits), 16'h054A);
        check("even parity done clk", doff, 33);
        step();
        parity_odd = 1'b1;
        stop2      = 1'b1;
        push(1, 8'hA5);
        capture(1, 3, 12, bits, doff);
        check("odd parity bits", int'(bits), 16'h0F4A);
        check("odd stop2 done clk", doff, 36);
        step();
        parity_odd = 1'b0;
        stop2      = 1'b0;
        baud_div   = 16'd4;

        // back-to-back 0x01, 0x80
        r0 = m[0].rd_cnt;
        push(0, 8'h01);
        push(0, 8'h80);
        capture(0, 4, 10, bits, doff);
        check("b2b first bits", int'(bits), 16'h0202);
        gap = 0;
        @(negedge clk);
        while (tx_w[0] === 1'b1 && gap < 20) begin
            gap++;
            @(negedge clk);
        end
        check("b2b gap clks", gap, 3);
        capture(0, 4, 10, bits, doff);
        check("b2b second bits", int'(bits), 16'h0300);
        check("b2b second done clk", doff, 40);
        step();
        check("b2b rd pulses", m[0].rd_cnt - r0, 2);

        // divisor clamp and mid-frame divisor change
        baud_div = 16'd0;
        push(0, 8'h55);
        capture(0, 2, 10, bits, doff);
        check("div0 bits", int'(bits), 16'h02AA);
        check("div0 done clk", doff, 20);
        step();
        baud_div = 16'd1;
        push(0, 8'h55);
        capture(0, 2, 10, bits, doff);
        check("div1 done clk", doff, 20);
        step();
        baud_div = 16'd4;
        push(0, 8'h0F);
        wait_fall(0);
        step();
        baud_div = 16'd8;
        stop2    = 1'b1;
        count_done(0, 1, doff);
        check("div change ignored done clk", doff, 40);
        step();
        baud_div = 16'd4;
        stop2    = 1'b0;

        // reset in the middle of the data bits of 0x3C
        push(0, 8'h3C);
        wait_fall(0);
        repeat (10) @(negedge clk);
        step();
        check("pre-reset tx low", int'(tx_w[0]), 0);
        rst_n = 1'b0;
        #1;
        check("async reset tx high", int'(tx_w[0]), 1);
        check("async reset busy low", int'(busy_w[0]), 0);
        step(2);
        rst_n = 1'b1;
        r0 = m[0].rd_cnt;
        d0 = m[0].done_cnt;
        step(20);
        check("post-reset no rd", m[0].rd_cnt - r0, 0);
        check("post-reset no done", m[0].done_cnt - d0, 0);

        // tx_en dropped during the second data bit with three bytes queued
        r0 = m[1].rd_cnt;
        push(1, 8'h11);
        push(1, 8'h22);
        push(1, 8'h33);
        wait_fall(1);
        repeat (8) @(negedge clk);
        step();
        tx_en = 1'b0;
        count_done(1, 1, doff);
        step(12);
        check("tx_en drop rd pulses", m[1].rd_cnt - r0, 1);
        check("tx_en drop busy", int'(busy_w[1]), 0);
        check("tx_en drop line idle", int'(tx_w[1]), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
